// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - one-entry ALU issue register with writeback forwarding and stall counter
module alu_issue_stage #(
  parameter int WIDTH = 64,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [RA_W-1:0]  in_rs1_addr,
  input  logic [RA_W-1:0]  in_rs2_addr,
  input  logic [RA_W-1:0]  in_rd_addr,
  input  logic [WIDTH-1:0] in_rs1_val,
  input  logic [WIDTH-1:0] in_rs2_val,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             wb_en,
  input  logic [RA_W-1:0]  wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       selection,
  output logic [WIDTH-1:0] input1,
  output logic [WIDTH-1:0] input2,
  output logic [RA_W-1:0]  out_rd_addr,
  output logic [15:0]      stall_count
);

  logic [RA_W-1:0]  held_rs1;
  logic [RA_W-1:0]  held_rs2;
  logic             held_use_imm;
  logic             accept;
  logic             stall;
  logic [WIDTH-1:0] fwd_rs1;
  logic [WIDTH-1:0] fwd_rs2;
  logic             refresh1;
  logic             refresh2;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign stall    = out_valid && !out_ready;

  // Register 0 is hardwired zero, so a writeback to it must never be forwarded.
  always_comb begin
    fwd_rs1 = in_rs1_val;
    fwd_rs2 = in_rs2_val;
    if (wb_en && (wb_addr == in_rs1_addr) && (in_rs1_addr != '0)) fwd_rs1 = wb_data;
    if (wb_en && (wb_addr == in_rs2_addr) && (in_rs2_addr != '0)) fwd_rs2 = wb_data;
  end

  // While stalled, late writebacks to the held sources keep the operands current.
  always_comb begin
    refresh1 = 1'b0;
    refresh2 = 1'b0;
    if (stall && !flush && wb_en && (wb_addr != '0)) begin
      refresh1 = (wb_addr == held_rs1);
      refresh2 = (wb_addr == held_rs2) && !held_use_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      selection    <= '0;
      input1       <= '0;
      input2       <= '0;
      out_rd_addr  <= '0;
      held_rs1     <= '0;
      held_rs2     <= '0;
      held_use_imm <= 1'b0;
      stall_count  <= '0;
    end else begin
      if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid    <= 1'b1;
        selection    <= in_op;
        out_rd_addr  <= in_rd_addr;
        input1       <= fwd_rs1;
        input2       <= in_use_imm ? in_imm : fwd_rs2;
        held_rs1     <= in_rs1_addr;
        held_rs2     <= in_rs2_addr;
        held_use_imm <= in_use_imm;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end else begin
        if (refresh1) input1 <= wb_data;
        if (refresh2) input2 <= wb_data;
      end
    end
  end

endmodule
